// File: rtl/sm4_encryptor_pkg.sv
// sm4_encryptor_pkg: SM4 constants, S-box and shared types for the round-key cache
package sm4_encryptor_pkg;
    localparam int group_size_p = 128;
    localparam int rk_width_p = 32;
    localparam logic [127:0] fk_lp = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [2047:0] sbox_lp = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    typedef enum logic [1:0] {IDLE, LOOKUP, EXPAND, DONE} state_e;
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        return sbox_lp[2047 - 8*int'(x) -: 8];
    endfunction
    // CK byte j of round r is (4r+j)*7 mod 256, most significant byte first
    function automatic logic [31:0] ck_f(input logic [4:0] r);
        logic [31:0] ck;
        ck = '0;
        for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*int'(r)+j)*7);
        return ck;
    endfunction
endpackage

// File: rtl/sm4_key_round.sv
// sm4_key_round: one SM4 key-schedule round, rk = K0 ^ T'(K1 ^ K2 ^ K3 ^ CK)
module sm4_key_round
    import sm4_encryptor_pkg::*;
(
    input  logic [rk_width_p-1:0] k0_i,
    input  logic [rk_width_p-1:0] k1_i,
    input  logic [rk_width_p-1:0] k2_i,
    input  logic [rk_width_p-1:0] k3_i,
    input  logic [rk_width_p-1:0] ck_i,
    output logic [rk_width_p-1:0] rk_o
);
    logic [rk_width_p-1:0] a;
    logic [rk_width_p-1:0] b;
    // Byte-wise S-box followed by the key-schedule linear transform L'
    always_comb begin
        a = k1_i ^ k2_i ^ k3_i ^ ck_i;
        b = {sbox_f(a[31:24]), sbox_f(a[23:16]), sbox_f(a[15:8]), sbox_f(a[7:0])};
        rk_o = k0_i ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    end
endmodule

// File: rtl/sm4_round_key_cache.sv
// sm4_round_key_cache: multi-way SM4 round-key cache with iterative expansion on miss
module sm4_round_key_cache
    import sm4_encryptor_pkg::*;
#(
    parameter int ways_p = 4,
    parameter int rounds_p = 32,
    localparam int way_w_lp = $clog2(ways_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [group_size_p-1:0] key_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [way_w_lp-1:0]     way_o,
    output logic                    cache_is_missed_o,
    input  logic                    invalid_cache_i,
    input  logic [way_w_lp-1:0]     rk_way_i,
    input  logic [4:0]              rk_idx_i,
    input  logic                    decode_i,
    output logic [rk_width_p-1:0]   rk_o,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
);
    state_e                  state_q, state_d;
    logic [group_size_p-1:0] key_q, key_d;
    logic [127:0]            k_q, k_d;
    logic [4:0]              rnd_q, rnd_d;
    logic [way_w_lp-1:0]     way_q, way_d;
    logic                    miss_q, miss_d;
    logic [ways_p-1:0]       valid_q, valid_d;
    logic [way_w_lp-1:0]     rr_q, rr_d;
    logic [31:0]             hit_cnt_q, hit_cnt_d;
    logic [31:0]             miss_cnt_q, miss_cnt_d;
    logic [rk_width_p-1:0]   rk_q, rk_d;
    logic [group_size_p-1:0] tag_q [ways_p];
    logic [rk_width_p-1:0]   rk_mem_q [ways_p][rounds_p];
    logic [ways_p-1:0]       live;
    logic                    hit, any_free, last_round;
    logic [way_w_lp-1:0]     hit_way, free_way;
    logic [rk_width_p-1:0]   ck, rk_new;

    assign ck = ck_f(rnd_q);
    assign last_round = rnd_q == 5'(rounds_p - 1);

    sm4_key_round u_round (
        .k0_i(k_q[127:96]),
        .k1_i(k_q[95:64]),
        .k2_i(k_q[63:32]),
        .k3_i(k_q[31:0]),
        .ck_i(ck),
        .rk_o(rk_new)
    );

    // Tag match and lowest free way, treating a same-cycle invalidate as already applied
    always_comb begin
        live = invalid_cache_i ? '0 : valid_q;
        hit = 1'b0;
        any_free = 1'b0;
        hit_way = '0;
        free_way = '0;
        for (int i = ways_p - 1; i >= 0; i--) begin
            if (live[i] && tag_q[i] == key_q) begin
                hit = 1'b1;
                hit_way = way_w_lp'(i);
            end
            if (!live[i]) begin
                any_free = 1'b1;
                free_way = way_w_lp'(i);
            end
        end
    end

    // Next-state logic for the lookup/expand FSM, counters and round-key readout
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        k_d = k_q;
        rnd_d = rnd_q;
        way_d = way_q;
        miss_d = miss_q;
        valid_d = live;
        rr_d = rr_q;
        hit_cnt_d = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: if (v_i) begin
                key_d = key_i;
                state_d = LOOKUP;
            end
            LOOKUP: if (hit) begin
                way_d = hit_way;
                miss_d = 1'b0;
                hit_cnt_d = hit_cnt_q + 32'd1;
                state_d = DONE;
            end else begin
                way_d = any_free ? free_way : rr_q;
                miss_d = 1'b1;
                miss_cnt_d = miss_cnt_q + 32'd1;
                k_d = key_q ^ fk_lp;
                rnd_d = '0;
                state_d = EXPAND;
            end
            EXPAND: begin
                k_d = {k_q[95:0], rk_new};
                rnd_d = rnd_q + 5'd1;
                if (last_round) begin
                    if (!invalid_cache_i) valid_d[way_q] = 1'b1;
                    rr_d = rr_q + way_w_lp'(1);
                    state_d = DONE;
                end
            end
            default: if (yumi_i) state_d = IDLE;
        endcase
        rk_d = rk_mem_q[rk_way_i][decode_i ? 5'(rounds_p - 1) - rk_idx_i : rk_idx_i];
    end

    // Control state, counters and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            key_q <= '0;
            k_q <= '0;
            rnd_q <= '0;
            way_q <= '0;
            miss_q <= 1'b0;
            valid_q <= '0;
            rr_q <= '0;
            hit_cnt_q <= '0;
            miss_cnt_q <= '0;
            rk_q <= '0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            k_q <= k_d;
            rnd_q <= rnd_d;
            way_q <= way_d;
            miss_q <= miss_d;
            valid_q <= valid_d;
            rr_q <= rr_d;
            hit_cnt_q <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            rk_q <= rk_d;
        end
    end

    // Round-key and tag storage; left unreset so it maps onto plain flops
    always_ff @(posedge clk_i) begin
        if (state_q == EXPAND) rk_mem_q[way_q][rnd_q] <= rk_new;
        if (state_q == EXPAND && last_round) tag_q[way_q] <= key_q;
    end

    assign ready_o = state_q == IDLE;
    assign v_o = state_q == DONE;
    assign way_o = way_q;
    assign cache_is_missed_o = miss_q;
    assign rk_o = rk_q;
    assign hit_count_o = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
endmodule

// File: tb/tb_sm4_round_key_cache.sv
// tb_sm4_round_key_cache: scoreboard-driven bench for the SM4 round-key cache
module tb_sm4_round_key_cache;
    logic         clk = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         v_i = 1'b0;
    logic         ready_o;
    logic         v_o;
    logic         yumi_i = 1'b0;
    logic [1:0]   way_o;
    logic         cache_is_missed_o;
    logic         invalid_cache_i = 1'b0;
    logic [1:0]   rk_way_i = '0;
    logic [4:0]   rk_idx_i = '0;
    logic         decode_i = 1'b0;
    logic [31:0]  rk_o;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    typedef struct {
        logic [1:0] way;
        logic       miss;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    localparam logic [127:0] key_a = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] key_b = 128'h11111111222222223333333344444444;
    localparam logic [127:0] key_c = 128'hdeadbeefcafef00d0badc0de12345678;
    localparam logic [127:0] key_d = 128'h00000000000000000000000000000001;
    localparam logic [127:0] key_e = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] key_g = 128'h5a5a5a5aa5a5a5a55a5a5a5aa5a5a5a5;
    localparam logic [31:0]  rk_first = 32'hf12186f9;
    localparam logic [31:0]  rk_last = 32'h9124a012;

    sm4_round_key_cache dut (
        .clk_i(clk),
        .reset_n_i(reset_n_i),
        .key_i(key_i),
        .v_i(v_i),
        .ready_o(ready_o),
        .v_o(v_o),
        .yumi_i(yumi_i),
        .way_o(way_o),
        .cache_is_missed_o(cache_is_missed_o),
        .invalid_cache_i(invalid_cache_i),
        .rk_way_i(rk_way_i),
        .rk_idx_i(rk_idx_i),
        .decode_i(decode_i),
        .rk_o(rk_o),
        .hit_count_o(hit_count_o),
        .miss_count_o(miss_count_o)
    );

    always #5 clk = ~clk;

    task automatic lookup(input logic [127:0] key, input logic [1:0] way, input logic miss, input int inv_at);
        exp_t e;
        int n;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL lookup_ready: ready_o=%b required 1", ready_o);
        end
        sb.push_back('{way, miss, miss ? 34 : 2});
        if (miss) exp_misses++;
        else exp_hits++;
        key_i = key;
        v_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v_i = 1'b0;
            invalid_cache_i = (n == inv_at);
        end while (v_o !== 1'b1 && n < 60);
        invalid_cache_i = 1'b0;
        e = sb.pop_front();
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL lookup_timeout: v_o=%b after %0d cycles, required 1", v_o, n);
        end
        checks++;
        if (n != e.lat) begin
            errors++;
            $display("FAIL lookup_latency: got %0d cycles, required %0d", n, e.lat);
        end
        checks++;
        if (way_o !== e.way) begin
            errors++;
            $display("FAIL lookup_way: way_o=%0d required %0d", way_o, e.way);
        end
        checks++;
        if (cache_is_missed_o !== e.miss) begin
            errors++;
            $display("FAIL lookup_missed: cache_is_missed_o=%b required %b", cache_is_missed_o, e.miss);
        end
        checks++;
        if (hit_count_o !== 32'(exp_hits) || miss_count_o !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL lookup_counters: hits=%0d misses=%0d required %0d %0d", hit_count_o, miss_count_o, exp_hits, exp_misses);
        end
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_ready: ready_o=%b v_o=%b required 1 0", ready_o, v_o);
        end
    endtask

    task automatic read_rk(input logic [1:0] way, input logic [4:0] idx, input logic dec, input logic [31:0] exp_rk);
        rk_way_i = way;
        rk_idx_i = idx;
        decode_i = dec;
        @(negedge clk);
        checks++;
        if (rk_o !== exp_rk) begin
            errors++;
            $display("FAIL rk_read: way %0d idx %0d dec %b rk_o=%h required %h", way, idx, dec, rk_o, exp_rk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || way_o !== 2'd0 || cache_is_missed_o !== 1'b0 ||
            rk_o !== 32'd0 || hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b v=%b way=%0d missed=%b rk=%h hits=%0d misses=%0d required 1 0 0 0 0 0 0",
                     ready_o, v_o, way_o, cache_is_missed_o, rk_o, hit_count_o, miss_count_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_miss_fill();
        lookup(key_a, 2'd0, 1'b1, -1);
        consume();
        read_rk(2'd0, 5'd0, 1'b0, rk_first);
        read_rk(2'd0, 5'd31, 1'b0, rk_last);
    endtask

    task automatic test_hit_decode();
        lookup(key_a, 2'd0, 1'b0, -1);
        consume();
        read_rk(2'd0, 5'd0, 1'b1, rk_last);
        read_rk(2'd0, 5'd31, 1'b1, rk_first);
    endtask

    task automatic test_eviction();
        logic [127:0] keys [6] = '{key_b, key_c, key_d, key_e, key_a, key_e};
        logic [1:0]   ways [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
        logic         miss [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            lookup(keys[i], ways[i], miss[i], -1);
            consume();
        end
        read_rk(2'd1, 5'd0, 1'b0, rk_first);
    endtask

    task automatic test_invalidate();
        invalid_cache_i = 1'b1;
        @(negedge clk);
        invalid_cache_i = 1'b0;
        lookup(key_e, 2'd0, 1'b1, -1);
        consume();
        lookup(key_a, 2'd1, 1'b1, 33);
        consume();
        read_rk(2'd1, 5'd0, 1'b0, rk_first);
        lookup(key_a, 2'd0, 1'b1, -1);
        consume();
    endtask

    task automatic test_stall();
        lookup(key_a, 2'd0, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            key_i = key_b;
            v_i = 1'b1;
            @(negedge clk);
            checks++;
            if (v_o !== 1'b1 || way_o !== 2'd0 || cache_is_missed_o !== 1'b0 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d v=%b way=%0d missed=%b ready=%b required 1 0 0 0",
                         i, v_o, way_o, cache_is_missed_o, ready_o);
            end
        end
        v_i = 1'b0;
        consume();
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || hit_count_o !== 32'(exp_hits) || miss_count_o !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL stall_idle: ready=%b v=%b hits=%0d misses=%0d required 1 0 %0d %0d",
                     ready_o, v_o, hit_count_o, miss_count_o, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset_mid_fill();
        key_i = key_g;
        v_i = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            v_i = 1'b0;
        end
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill_busy: ready=%b v=%b required 0 0", ready_o, v_o);
        end
        reset_n_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        exp_hits = 0;
        exp_misses = 0;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
            errors++;
            $display("FAIL mid_fill_reset: ready=%b v=%b hits=%0d misses=%0d required 1 0 0 0",
                     ready_o, v_o, hit_count_o, miss_count_o);
        end
        lookup(key_a, 2'd0, 1'b1, -1);
        consume();
        read_rk(2'd0, 5'd31, 1'b0, rk_last);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit_decode();
        test_eviction();
        test_invalidate();
        test_stall();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
